// File: rtl/uart_tx_arb.sv
// ============================================================================
// Module   : uart_tx_arb
// Purpose  : Message-granular round-robin arbiter in front of the UART
//            transmit buffer write port, with an idle-owner reclaim timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int TO_WIDTH = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_mask,
  input  logic [TO_WIDTH-1:0]   lock_timeout,
  input  logic                  tx_ready,
  output logic                  tx_data_reg_wr,
  output logic [7:0]            tx_data,
  output logic [ID_WIDTH-1:0]   grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOCK = 2'b01
  } state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [TO_WIDTH-1:0]   r_cnt;

  logic [NUM_REQ-1:0]    w_elig;
  logic [2*NUM_REQ-1:0]  w_elig2;
  logic [NUM_REQ-1:0]    w_rot;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_off;
  logic [ID_WIDTH:0]     w_sum;
  logic [ID_WIDTH-1:0]   w_pick;

  logic                  w_own_valid;
  logic                  w_own_last;
  logic                  w_own_mask;
  logic [7:0]            w_own_data;
  logic                  w_own_ready;
  logic                  w_hs;
  logic [ID_WIDTH-1:0]   w_ptr_next;
  logic [TO_WIDTH-1:0]   w_cnt_inc;
  logic                  w_to_hit;

  // Rotate the eligible vector so bit 0 is the pointer position; the lowest
  // set bit of the rotated view is then the round-robin winner.
  assign w_elig  = req_valid & req_mask;
  assign w_elig2 = {w_elig, w_elig};
  assign w_rot   = w_elig2[r_ptr +: NUM_REQ];
  assign w_found = |w_rot;

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = ID_WIDTH'(k);
      end
    end
    w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    w_pick = (w_sum >= (ID_WIDTH+1)'(NUM_REQ)) ?
             ID_WIDTH'(w_sum - (ID_WIDTH+1)'(NUM_REQ)) : ID_WIDTH'(w_sum);
  end

  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_mask  = 1'b0;
    w_own_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
        w_own_mask  = req_mask[i];
        w_own_data  = req_data[8*i +: 8];
      end
    end
  end

  // Blocking the cycle after a write gives the buffer time to update tx_ready.
  assign w_own_ready = (r_state == ST_LOCK) & tx_ready & ~tx_data_reg_wr & w_own_mask;
  assign w_hs        = w_own_valid & w_own_ready;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        req_ready[i] = w_own_ready;
      end
    end
  end

  assign w_ptr_next = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + TO_WIDTH'(1);
  // Compare against the post-increment value so the release edge lands on the
  // cycle the counter would reach the programmed limit.
  assign w_to_hit   = (lock_timeout != '0) & ~w_own_valid & (w_cnt_inc >= lock_timeout);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_cnt          <= '0;
      grant_id       <= '0;
      busy           <= 1'b0;
      tx_data_reg_wr <= 1'b0;
      tx_data        <= 8'h00;
      timeout_err    <= 1'b0;
    end else begin
      tx_data_reg_wr <= w_hs;
      timeout_err    <= 1'b0;
      if (w_hs) begin
        tx_data <= w_own_data;
      end
      case (r_state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (w_found) begin
            r_state  <= ST_LOCK;
            busy     <= 1'b1;
            grant_id <= w_pick;
            r_cnt    <= '0;
          end
        end
        ST_LOCK: begin
          if (w_hs) begin
            r_cnt <= '0;
            if (w_own_last) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
              r_ptr   <= w_ptr_next;
            end
          end else if (!w_own_mask) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            r_ptr   <= w_ptr_next;
          end else if (w_to_hit) begin
            r_state     <= ST_IDLE;
            busy        <= 1'b0;
            r_ptr       <= w_ptr_next;
            timeout_err <= 1'b1;
          end else if (!w_own_valid) begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
// Module   : tb_uart_tx_arb
// Purpose  : Scoreboard bench for uart_tx_arb with queue-driven requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;

  logic        PCLK;
  logic        PRESETN;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  req_mask;
  logic [15:0] lock_timeout;
  logic        tx_ready;
  logic        tx_data_reg_wr;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  uart_tx_arb #(.NUM_REQ(4), .ID_WIDTH(2), .TO_WIDTH(16)) dut (
    .PCLK           (PCLK),
    .PRESETN        (PRESETN),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .req_mask       (req_mask),
    .lock_timeout   (lock_timeout),
    .tx_ready       (tx_ready),
    .tx_data_reg_wr (tx_data_reg_wr),
    .tx_data        (tx_data),
    .grant_id       (grant_id),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    int id;
    int data;
    int cyc;
  } exp_t;

  exp_t        sb[$];
  logic [8:0]  rq[4][$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          n_wr    = 0;
  int          n_toerr = 0;
  int          last_wr_cyc = 0;
  int          toerr_cyc   = 0;
  logic        toerr_busy  = 1'b0;
  int          base, t0, hs_cyc;
  logic [7:0]  busy_pat;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic present();
    logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        e = rq[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = e[7:0];
        req_last[i]        = e[8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  // Queue a byte on requester r; when it is expected on the line, record the
  // owner/byte (and optionally the exact cycle) in the scoreboard.
  task automatic put(input int r, input logic [7:0] d, input logic last,
                     input logic expect_wr, input int ecyc);
    exp_t e;
    rq[r].push_back({last, d});
    if (expect_wr) begin
      e.id = r; e.data = int'(d); e.cyc = ecyc;
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #2;
  endtask

  task automatic wait_writes(input int target);
    int k = 0;
    while (n_wr < target && k < 400) begin
      @(negedge PCLK);
      #1;
      k++;
    end
    if (n_wr < target) chk("wait_wr", n_wr, target);
  endtask

  // Requester model: pop a byte when it was accepted at the preceding edge.
  initial begin
    logic [3:0] acc;
    forever begin
      @(negedge PCLK);
      acc = req_valid & req_ready;
      @(posedge PCLK);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      present();
    end
  end

  // Write monitor / scoreboard check.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (tx_data_reg_wr === 1'b1) begin
        n_wr++;
        last_wr_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_wr", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_data", {24'h0, tx_data}, e.data);
          chk("wr_owner", {30'h0, grant_id}, e.id);
          if (e.cyc >= 0) chk("wr_cycle", cyc, e.cyc);
        end
      end
      if (timeout_err === 1'b1) begin
        n_toerr++;
        toerr_cyc  = cyc;
        toerr_busy = busy;
      end
    end
  end

  initial begin
    PRESETN      = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    req_mask     = 4'b1111;
    lock_timeout = '0;
    tx_ready     = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_wr", tx_data_reg_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_toerr", timeout_err, 0);
    step();
    PRESETN = 1'b1;
    step();

    // Single message from req0 with exact write cycles and busy profile.
    t0 = cyc;
    put(0, 8'h41, 1'b0, 1'b1, t0 + 2);
    put(0, 8'h42, 1'b0, 1'b1, t0 + 4);
    put(0, 8'h43, 1'b1, 1'b1, t0 + 6);
    present();
    busy_pat = 8'b0011_1110;
    for (int k = 0; k < 8; k++) begin
      @(negedge PCLK);
      chk("single_busy", busy, busy_pat[k]);
      if (k == 1) chk("single_grant", grant_id, 0);
    end

    // Round robin: pointer 1 -> req1 then req3; pointer 0 -> req0 then req1;
    // pointer 2 -> req3 then req0 (wrap).
    step();
    base = n_wr;
    put(1, 8'hA1, 1'b1, 1'b1, -1);
    put(3, 8'hA3, 1'b1, 1'b1, -1);
    present();
    wait_writes(base + 2);
    step();
    base = n_wr;
    put(0, 8'hB0, 1'b1, 1'b1, -1);
    put(1, 8'hB1, 1'b1, 1'b1, -1);
    present();
    wait_writes(base + 2);
    step();
    base = n_wr;
    put(3, 8'hC3, 1'b1, 1'b1, -1);
    put(0, 8'hC0, 1'b1, 1'b1, -1);
    present();
    wait_writes(base + 2);

    // Backpressure on req1 (pointer 1) for 20 cycles with timeout 5.
    step();
    lock_timeout = 16'd5;
    base = n_wr;
    put(1, 8'h51, 1'b0, 1'b1, -1);
    put(1, 8'h52, 1'b0, 1'b1, -1);
    put(1, 8'h53, 1'b1, 1'b1, -1);
    present();
    wait_writes(base + 1);
    step();
    tx_ready = 1'b0;
    repeat (20) step();
    chk("bp_no_wr", n_wr, base + 1);
    chk("bp_no_toerr", n_toerr, 0);
    chk("bp_busy", busy, 1);
    tx_ready = 1'b1;
    wait_writes(base + 3);
    chk("bp_toerr_after", n_toerr, 0);

    // Timeout: req2 (pointer 2) stalls after one byte; req3 follows.
    step();
    lock_timeout = 16'd8;
    base = n_wr;
    put(2, 8'h61, 1'b0, 1'b1, -1);
    put(3, 8'h71, 1'b1, 1'b1, -1);
    present();
    wait_writes(base + 1);
    hs_cyc = last_wr_cyc - 1;
    for (int k = 0; k < 60 && n_toerr < 1; k++) begin
      @(negedge PCLK);
      #1;
    end
    chk("to_pulse", n_toerr, 1);
    chk("to_cycle", toerr_cyc, hs_cyc + 9);
    chk("to_idle", toerr_busy, 0);
    wait_writes(base + 2);
    chk("to_single_pulse", n_toerr, 1);
    lock_timeout = '0;

    // Mask clear on req0 (pointer 0) during its second byte.
    step();
    base = n_wr;
    put(0, 8'h21, 1'b0, 1'b1, -1);
    put(0, 8'h22, 1'b0, 1'b0, -1);
    put(0, 8'h23, 1'b1, 1'b0, -1);
    present();
    wait_writes(base + 1);
    step();
    chk("mask_rdy_pre", req_ready[0], 1);
    #1;
    req_mask[0] = 1'b0;
    #1;
    chk("mask_rdy_drop", req_ready[0], 0);
    chk("mask_busy_same", busy, 1);
    step();
    @(negedge PCLK);
    chk("mask_idle", busy, 0);
    chk("mask_no_toerr", timeout_err, 0);
    rq[0].delete();
    present();
    repeat (3) step();
    req_mask = 4'b1111;
    repeat (4) step();
    chk("mask_no_more_wr", n_wr, base + 1);
    chk("mask_toerr_total", n_toerr, 1);

    // Asynchronous reset while req1 (pointer 1) is mid-message.
    step();
    base = n_wr;
    put(1, 8'h11, 1'b0, 1'b1, -1);
    put(1, 8'h12, 1'b0, 1'b0, -1);
    put(1, 8'h13, 1'b1, 1'b0, -1);
    present();
    wait_writes(base + 1);
    #1;
    PRESETN = 1'b0;
    #1;
    chk("arst_wr", tx_data_reg_wr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_grant", grant_id, 0);
    chk("arst_data", tx_data, 0);
    rq[1].delete();
    sb.delete();
    present();
    repeat (3) @(posedge PCLK);
    #2;
    PRESETN = 1'b1;
    step();
    base = n_wr;
    put(0, 8'h31, 1'b1, 1'b1, -1);
    put(2, 8'h32, 1'b1, 1'b1, -1);
    present();
    wait_writes(base + 2);
    repeat (4) step();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
